// File: rtl/csr_trap_unit_if.sv
// CSR access, trap request and trap-redirect signals between the EX stage and csr_trap_unit.
interface csr_trap_unit_if #(
    parameter int NUM_IRQ = 4
);
    logic               csr_re;
    logic [11:0]        csr_raddr;
    logic [31:0]        csr_rdata;
    logic [1:0]         csr_op;
    logic [11:0]        csr_waddr;
    logic [31:0]        csr_wdata;
    logic               illegal_csr;
    logic [NUM_IRQ-1:0] irq_i;
    logic               exc_i;
    logic [3:0]         exc_cause;
    logic               ecall_i;
    logic [31:0]        trap_pc_i;
    logic [31:0]        exc_tval;
    logic               mret_i;
    logic               instr_retire;
    logic               trap_o;
    logic [31:0]        trap_target;
    logic [31:0]        mepc_o;

    modport master (
        output csr_re, csr_raddr, csr_op, csr_waddr, csr_wdata, irq_i, exc_i, exc_cause,
               ecall_i, trap_pc_i, exc_tval, mret_i, instr_retire,
        input  csr_rdata, illegal_csr, trap_o, trap_target, mepc_o
    );
    modport slave (
        input  csr_re, csr_raddr, csr_op, csr_waddr, csr_wdata, irq_i, exc_i, exc_cause,
               ecall_i, trap_pc_i, exc_tval, mret_i, instr_retire,
        output csr_rdata, illegal_csr, trap_o, trap_target, mepc_o
    );
endinterface

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap sequencer with vectored mtvec and prioritised interrupts.
// Define CSR_COUNTERS_EN to add the 64-bit mcycle/minstret counters.
module csr_trap_unit #(
    parameter int          NUM_IRQ     = 4,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
    parameter logic [31:0] MISA_VAL    = 32'h4000_0100
) (
    input logic            clk,
    input logic            Rst,
    csr_trap_unit_if.slave bus
);
    localparam logic [3:0] I_MSTATUS = 4'd0, I_MISA = 4'd1, I_MIE = 4'd2, I_MTVEC = 4'd3,
                           I_MSCRATCH = 4'd4, I_MEPC = 4'd5, I_MCAUSE = 4'd6, I_MTVAL = 4'd7,
                           I_MIP = 4'd8, I_MCYC = 4'd9, I_MCYCH = 4'd10, I_MINS = 4'd11,
                           I_MINSH = 4'd12;

    // Address decode returns {implemented, view index}.
    function automatic logic [4:0] dec(input logic [11:0] a);
        case (a)
            12'h300: return {1'b1, I_MSTATUS};
            12'h301: return {1'b1, I_MISA};
            12'h304: return {1'b1, I_MIE};
            12'h305: return {1'b1, I_MTVEC};
            12'h340: return {1'b1, I_MSCRATCH};
            12'h341: return {1'b1, I_MEPC};
            12'h342: return {1'b1, I_MCAUSE};
            12'h343: return {1'b1, I_MTVAL};
            12'h344: return {1'b1, I_MIP};
`ifdef CSR_COUNTERS_EN
            12'hB00: return {1'b1, I_MCYC};
            12'hB80: return {1'b1, I_MCYCH};
            12'hB02: return {1'b1, I_MINS};
            12'hB82: return {1'b1, I_MINSH};
`endif
            default: return 5'd0;
        endcase
    endfunction

    logic               st_mie_q, st_mie_d, st_mpie_q, st_mpie_d;
    logic [NUM_IRQ-1:0] mie_q, mie_d;
    logic [31:0]        mtvec_q, mtvec_d, mscratch_q, mscratch_d, mepc_q, mepc_d;
    logic [31:0]        mcause_q, mcause_d, mtval_q, mtval_d;
    logic [63:0]        cycle_q, instret_q;
`ifdef CSR_COUNTERS_EN
    logic [63:0]        cycle_d, instret_d;
`endif

    logic [15:0][31:0] view;
    logic        rhit, whit, ro_w, wr_act, wr_ok;
    logic [3:0]  ridx, widx;
    logic [31:0] nv, base;
    logic [NUM_IRQ-1:0] irq_pend;
    logic [4:0]  irq_code;
    logic        trap_req, is_irq;
    logic [31:0] unused_bits;

    assign unused_bits = {29'd0, bus.instr_retire, bus.trap_pc_i[1:0]};

    always_comb begin
        view            = '0;
        view[I_MSTATUS] = {24'd0, st_mpie_q, 3'd0, st_mie_q, 3'd0};
        view[I_MISA]    = MISA_VAL;
        view[I_MIE][16 +: NUM_IRQ] = mie_q;
        view[I_MTVEC]   = mtvec_q;
        view[I_MSCRATCH] = mscratch_q;
        view[I_MEPC]    = mepc_q;
        view[I_MCAUSE]  = mcause_q;
        view[I_MTVAL]   = mtval_q;
        view[I_MIP][16 +: NUM_IRQ] = bus.irq_i;
        view[I_MCYC]    = cycle_q[31:0];
        view[I_MCYCH]   = cycle_q[63:32];
        view[I_MINS]    = instret_q[31:0];
        view[I_MINSH]   = instret_q[63:32];
    end

    assign {rhit, ridx} = dec(bus.csr_raddr);
    assign {whit, widx} = dec(bus.csr_waddr);
    assign ro_w   = (widx == I_MISA) || (widx == I_MIP);
    assign wr_act = bus.csr_op != 2'b00;
    assign wr_ok  = wr_act && whit && !ro_w;

    assign bus.csr_rdata   = rhit ? view[ridx] : 32'd0;
    assign bus.illegal_csr = Rst && ((bus.csr_re && !rhit) || (wr_act && (!whit || ro_w)));

    always_comb begin
        case (bus.csr_op)
            2'b10:   nv = view[widx] | bus.csr_wdata;
            2'b11:   nv = view[widx] & ~bus.csr_wdata;
            default: nv = bus.csr_wdata;
        endcase
    end

    // Lowest-numbered pending line wins: scan downwards so the last hit sticks.
    always_comb begin
        irq_pend = mie_q & bus.irq_i & {NUM_IRQ{st_mie_q}};
        irq_code = 5'd0;
        for (int k = NUM_IRQ - 1; k >= 0; k--)
            if (irq_pend[k]) irq_code = 5'(16 + k);
    end

    assign trap_req = bus.exc_i || bus.ecall_i || (|irq_pend);
    assign is_irq   = !bus.exc_i && !bus.ecall_i;
    assign base     = {mtvec_q[31:2], 2'b00};
    assign bus.trap_o      = Rst && trap_req;
    assign bus.trap_target = (is_irq && mtvec_q[1:0] == 2'b01) ?
                             base + {25'd0, irq_code, 2'b00} : base;
    assign bus.mepc_o      = mepc_q;

    // Later assignments win: CSR write < mret < trap.
    always_comb begin
        st_mie_d   = st_mie_q;
        st_mpie_d  = st_mpie_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        if (wr_ok) begin
            case (widx)
                I_MSTATUS:  begin st_mie_d = nv[3]; st_mpie_d = nv[7]; end
                I_MIE:      mie_d = nv[16 +: NUM_IRQ];
                I_MTVEC:    mtvec_d = {nv[31:2], 1'b0, nv[1] ? 1'b0 : nv[0]};
                I_MSCRATCH: mscratch_d = nv;
                I_MEPC:     mepc_d = {nv[31:2], 2'b00};
                I_MCAUSE:   mcause_d = nv;
                I_MTVAL:    mtval_d = nv;
                default: ;
            endcase
        end
        if (bus.mret_i && !trap_req) begin
            st_mie_d  = st_mpie_q;
            st_mpie_d = 1'b1;
        end
        if (trap_req) begin
            mepc_d    = {bus.trap_pc_i[31:2], 2'b00};
            mcause_d  = bus.exc_i ? {28'd0, bus.exc_cause} :
                        bus.ecall_i ? 32'd11 : {1'b1, 26'd0, irq_code};
            mtval_d   = bus.exc_i ? bus.exc_tval : 32'd0;
            st_mpie_d = st_mie_q;
            st_mie_d  = 1'b0;
        end
    end

`ifdef CSR_COUNTERS_EN
    // A write to one half replaces that counter's increment for the cycle.
    always_comb begin
        cycle_d   = cycle_q + 64'd1;
        instret_d = instret_q + {63'd0, bus.instr_retire};
        if (wr_ok && widx == I_MCYC)  cycle_d   = {cycle_q[63:32], nv};
        if (wr_ok && widx == I_MCYCH) cycle_d   = {nv, cycle_q[31:0]};
        if (wr_ok && widx == I_MINS)  instret_d = {instret_q[63:32], nv};
        if (wr_ok && widx == I_MINSH) instret_d = {nv, instret_q[31:0]};
    end

    always_ff @(posedge clk) begin
        if (!Rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end
`else
    assign cycle_q   = '0;
    assign instret_q = '0;
`endif

    always_ff @(posedge clk) begin
        if (!Rst) begin
            st_mie_q   <= 1'b0;
            st_mpie_q  <= 1'b0;
            mie_q      <= '0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else begin
            st_mie_q   <= st_mie_d;
            st_mpie_q  <= st_mpie_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
        end
    end
endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed-vector bench for csr_trap_unit; expected values are hand-computed constants.
module tb_csr_trap_unit;
    logic clk = 1'b0;
    logic Rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    csr_trap_unit_if #(.NUM_IRQ(4)) bus();

    csr_trap_unit #(
        .NUM_IRQ(4), .MTVEC_RESET(32'h0000_0100), .MISA_VAL(32'h4000_0100)
    ) dut (
        .clk(clk), .Rst(Rst), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        bus.csr_re    = 1'b1;
        bus.csr_raddr = a;
        #1;
        chk(tag, bus.csr_rdata, exp);
        bus.csr_re    = 1'b0;
    endtask

    task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        bus.csr_op    = op;
        bus.csr_waddr = a;
        bus.csr_wdata = d;
        tick();
        bus.csr_op    = 2'b00;
    endtask

    task automatic idle();
        bus.csr_re = 0; bus.csr_raddr = '0; bus.csr_op = '0; bus.csr_waddr = '0;
        bus.csr_wdata = '0; bus.irq_i = '0; bus.exc_i = 0; bus.exc_cause = '0;
        bus.ecall_i = 0; bus.trap_pc_i = '0; bus.exc_tval = '0; bus.mret_i = 0;
        bus.instr_retire = 0;
    endtask

    initial begin
        idle();
        // Reset: outputs gated even with a pending exception and a bad read address
        tick(); tick();
        bus.exc_i = 1'b1; bus.csr_re = 1'b1; bus.csr_raddr = 12'h7C0;
        #1;
        chk("rst_trap_o", {31'd0, bus.trap_o}, 32'd0);
        chk("rst_illegal", {31'd0, bus.illegal_csr}, 32'd0);
        idle();
        chk_rd("rst_mtvec", 12'h305, 32'h0000_0100);
        Rst = 1'b1;
        tick();

        wr(2'b01, 12'h340, 32'hDEAD_BEEF);
        chk_rd("mscratch_wr", 12'h340, 32'hDEAD_BEEF);
        Rst = 1'b0;
        tick();
        Rst = 1'b1;
        chk_rd("rst2_mscratch", 12'h340, 32'd0);
        chk_rd("rst2_mtvec", 12'h305, 32'h0000_0100);
        chk("rst2_trap_o", {31'd0, bus.trap_o}, 32'd0);

        // Set/clear and writable mask on mie
        wr(2'b01, 12'h304, 32'd0);
        wr(2'b10, 12'h304, 32'h0003_0000);
        chk_rd("mie_set", 12'h304, 32'h0003_0000);
        wr(2'b11, 12'h304, 32'h0001_0000);
        chk_rd("mie_clr", 12'h304, 32'h0002_0000);
        wr(2'b01, 12'h304, 32'hFFFF_FFFF);
        chk_rd("mie_mask", 12'h304, 32'h000F_0000);

        // Read-only and unimplemented accesses
        chk_rd("misa_rd", 12'h301, 32'h4000_0100);
        bus.csr_op = 2'b01; bus.csr_waddr = 12'h301; bus.csr_wdata = 32'h0;
        #1;
        chk("misa_wr_illegal", {31'd0, bus.illegal_csr}, 32'd1);
        tick();
        bus.csr_op = 2'b00;
        chk_rd("misa_kept", 12'h301, 32'h4000_0100);
        bus.csr_op = 2'b10; bus.csr_waddr = 12'h344;
        #1;
        chk("mip_wr_illegal", {31'd0, bus.illegal_csr}, 32'd1);
        bus.csr_op = 2'b00;
        bus.csr_re = 1'b1; bus.csr_raddr = 12'h7C0;
        #1;
        chk("unimpl_illegal", {31'd0, bus.illegal_csr}, 32'd1);
        chk("unimpl_rdata", bus.csr_rdata, 32'd0);
        bus.csr_raddr = 12'h340;
        #1;
        chk("legal_rd_ok", {31'd0, bus.illegal_csr}, 32'd0);
        bus.csr_re = 1'b0;

        // WARL mtvec mode and aligned mepc
        wr(2'b01, 12'h305, 32'h0000_0203);
        chk_rd("mtvec_warl", 12'h305, 32'h0000_0200);
        wr(2'b01, 12'h341, 32'h0000_0007);
        chk_rd("mepc_align", 12'h341, 32'h0000_0004);

        // Vectored interrupt on line 2
        wr(2'b01, 12'h305, 32'h0000_0201);
        wr(2'b01, 12'h304, 32'h0004_0000);
        wr(2'b10, 12'h300, 32'h0000_0008);
        bus.irq_i = 4'b0100; bus.trap_pc_i = 32'h0000_0080;
        #1;
        chk("irq_trap_o", {31'd0, bus.trap_o}, 32'd1);
        chk("irq_target", bus.trap_target, 32'h0000_0248);
        tick();
        chk("irq_no_retrig", {31'd0, bus.trap_o}, 32'd0);
        bus.irq_i = '0;
        chk_rd("irq_mcause", 12'h342, 32'h8000_0012);
        chk_rd("irq_mepc", 12'h341, 32'h0000_0080);
        chk_rd("irq_mstatus", 12'h300, 32'h0000_0080);

        bus.mret_i = 1'b1;
        #1;
        chk("mret_trap_o", {31'd0, bus.trap_o}, 32'd0);
        tick();
        bus.mret_i = 1'b0;
        chk_rd("mret_mstatus", 12'h300, 32'h0000_0088);
        chk("mret_mepc_o", bus.mepc_o, 32'h0000_0080);

        // Priority: exception beats ecall, interrupt and mret
        wr(2'b01, 12'h304, 32'h000F_0000);
        bus.exc_i = 1; bus.exc_cause = 4'd2; bus.ecall_i = 1; bus.irq_i = 4'b0001;
        bus.mret_i = 1; bus.trap_pc_i = 32'h0000_0044; bus.exc_tval = 32'hBAD0_0000;
        #1;
        chk("exc_target", bus.trap_target, 32'h0000_0200);
        tick();
        idle();
        chk_rd("exc_mcause", 12'h342, 32'h0000_0002);
        chk_rd("exc_mtval", 12'h343, 32'hBAD0_0000);
        chk_rd("exc_mstatus", 12'h300, 32'h0000_0080);
        bus.mret_i = 1'b1;
        tick();
        bus.mret_i = 1'b0;
        chk_rd("mret2_mstatus", 12'h300, 32'h0000_0088);
        chk("mret2_mepc_o", bus.mepc_o, 32'h0000_0044);

        // ecall clears mtval
        bus.ecall_i = 1'b1; bus.trap_pc_i = 32'h0000_0050;
        tick();
        bus.ecall_i = 1'b0;
        chk_rd("ecall_mcause", 12'h342, 32'h0000_000B);
        chk_rd("ecall_mtval", 12'h343, 32'd0);
        bus.mret_i = 1'b1;
        tick();
        bus.mret_i = 1'b0;

        // Lowest line wins; a concurrent mscratch write still lands
        bus.irq_i = 4'b1010; bus.trap_pc_i = 32'h0000_0060;
        bus.csr_op = 2'b01; bus.csr_waddr = 12'h340; bus.csr_wdata = 32'h1234_5678;
        #1;
        chk("lowk_target", bus.trap_target, 32'h0000_0244);
        tick();
        idle();
        chk_rd("lowk_mcause", 12'h342, 32'h8000_0011);
        chk_rd("lowk_mscratch", 12'h340, 32'h1234_5678);

        // mret beats an mstatus write in the same cycle
        bus.mret_i = 1'b1;
        bus.csr_op = 2'b11; bus.csr_waddr = 12'h300; bus.csr_wdata = 32'h0000_0080;
        tick();
        idle();
        chk_rd("mret_vs_wr", 12'h300, 32'h0000_0088);

`ifdef CSR_COUNTERS_EN
        wr(2'b01, 12'hB00, 32'hFFFF_FFFF);
        chk_rd("mcycle_set", 12'hB00, 32'hFFFF_FFFF);
        chk_rd("mcycleh_pre", 12'hB80, 32'd0);
        tick();
        chk_rd("mcycleh_carry", 12'hB80, 32'd1);
        chk_rd("mcycle_wrap", 12'hB00, 32'd0);
        wr(2'b01, 12'hB02, 32'd5);
        chk_rd("minstret_set", 12'hB02, 32'd5);
        bus.instr_retire = 1'b1;
        tick(); tick(); tick();
        bus.instr_retire = 1'b0;
        chk_rd("minstret_cnt", 12'hB02, 32'd8);
`else
        bus.csr_re = 1'b1; bus.csr_raddr = 12'hB00;
        #1;
        chk("nocnt_illegal", {31'd0, bus.illegal_csr}, 32'd1);
        chk("nocnt_rdata", bus.csr_rdata, 32'd0);
        bus.csr_re = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
